seq_pattern_tx: RTL and testbench

Programmable serial pattern transmitter. It accepts a parallel pattern of up to MAX_LEN bits through a valid/ready handshake and shifts it out MSB-first at one bit per BIT_CYCLES clocks. Frames repeat a programmable number of times, with an optional low gap between frames. It is the stimulus source for the sequence-detector path and replaces the fixed hard-coded generators, so any target pattern (e.g. 111010011) can be driven to the detector at runtime.

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_bit_timer.sv | 46 ++++
 rtl/seq_pattern_tx.sv | 177 +++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_t / ST_*  : FSM encoding (IDLE, SHIFT, GAP)
//   FRAME_CNT_W     : width of the frame counter and repeat_cnt
//   len_w()         : width of the len port for a given MAX_LEN
package seq_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_GAP   = 2'd2;

   localparam int FRAME_CNT_W = 8;

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_bit_timer.sv
// Bit-period timer for seq_pattern_tx.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart at the first cycle of a new transfer (accept)
//   en        : transmitter is active (SHIFT or GAP)
//   halt      : the bit now ending is the last one of the transfer
//   bit_tick  : registered pulse on the first cycle of every bit period
//   bit_end   : combinational strobe on the last cycle of a bit period
module seq_bit_timer #(
   parameter int BIT_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   input  logic halt,
   output logic bit_tick,
   output logic bit_end
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] cnt;

   assign bit_end = en && (cnt == LAST);

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         bit_tick <= 1'b0;
      end else if (clear) begin
         cnt      <= '0;
         bit_tick <= 1'b1;
      end else if (en) begin
         cnt      <= bit_end ? '0 : cnt + CW'(1);
         // No tick for a period that will never start (transfer ending).
         bit_tick <= bit_end && !halt;
      end else begin
         cnt      <= '0;
         bit_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// Programmable serial pattern transmitter.
// Shifts a latched pattern out MSB-first, one bit per BIT_CYCLES clocks,
// repeating frames with an optional forced-low gap between them.
//   clk, rst                 : clock, synchronous active-high reset
//   start_valid/start_ready  : accept handshake (ready only in IDLE)
//   pattern, len, repeat_cnt : transfer description, latched at accept
//   stop                     : end after the current frame (sticky)
//   seq, seq_valid           : serial bit and its qualifier
//   bit_tick                 : first cycle of every bit period
//   frame_start              : first cycle of every frame
//   busy, done               : transfer in progress / completion pulse
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int MAX_LEN    = 16,
   parameter int BIT_CYCLES = 500000,
   parameter int GAP_BITS   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_valid,
   output logic                     start_ready,
   input  logic [MAX_LEN-1:0]       pattern,
   input  logic [len_w(MAX_LEN)-1:0] len,
   input  logic [FRAME_CNT_W-1:0]   repeat_cnt,
   input  logic                     stop,
   output logic                     seq,
   output logic                     seq_valid,
   output logic                     bit_tick,
   output logic                     frame_start,
   output logic                     busy,
   output logic                     done
);

   localparam int LEN_W = len_w(MAX_LEN);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   state_t                 state;
   logic [MAX_LEN-1:0]     pat_q;     // pattern left-aligned: first bit at MSB
   logic [MAX_LEN-1:0]     sh_q;      // remaining bits of the current frame
   logic [LEN_W-1:0]       len_q;
   logic [LEN_W-1:0]       bit_idx;
   logic [FRAME_CNT_W-1:0] rep_q;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic [GW-1:0]          gap_cnt;
   logic                   stop_q;

   logic                   accept;
   logic [LEN_W-1:0]       len_eff;
   logic [MAX_LEN-1:0]     pat_align;
   logic                   stop_now;
   logic                   frame_last;
   logic                   gap_last;
   logic                   halt;
   logic                   bit_end;

   assign start_ready = (state == ST_IDLE);

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      accept     = start_valid && start_ready;
      len_eff    = (len > MAX_LEN_L) ? MAX_LEN_L : len;
      pat_align  = pattern << (MAX_LEN_L - len_eff);
      stop_now   = stop_q || stop;
      frame_last = (rep_q != '0) && (frame_cnt == rep_q);
      gap_last   = (gap_cnt == GAP_LAST);
      halt       = 1'b0;
      if (bit_end) begin
         if (state == ST_SHIFT && bit_idx == '0) begin
            halt = stop_now || frame_last;
         end else if (state == ST_GAP && gap_last) begin
            halt = stop_now;
         end
      end
   end

   seq_bit_timer #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept && (len_eff != '0)),
      .en       (state != ST_IDLE),
      .halt     (halt),
      .bit_tick (bit_tick),
      .bit_end  (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pat_q       <= '0;
         sh_q        <= '0;
         len_q       <= '0;
         bit_idx     <= '0;
         rep_q       <= '0;
         frame_cnt   <= '0;
         gap_cnt     <= '0;
         stop_q      <= 1'b0;
         seq         <= 1'b0;
         seq_valid   <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         done        <= 1'b0;
         if (state != ST_IDLE && stop) begin
            stop_q <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (len_eff == '0) begin
                     done <= 1'b1;
                  end else begin
                     state       <= ST_SHIFT;
                     pat_q       <= pat_align;
                     sh_q        <= pat_align << 1;
                     seq         <= pat_align[MAX_LEN-1];
                     seq_valid   <= 1'b1;
                     len_q       <= len_eff;
                     bit_idx     <= len_eff - LEN_W'(1);
                     rep_q       <= repeat_cnt;
                     frame_cnt   <= FRAME_CNT_W'(1);
                     frame_start <= 1'b1;
                     busy        <= 1'b1;
                     stop_q      <= 1'b0;
                  end
               end
            end

            ST_SHIFT, ST_GAP: begin
               if (bit_end) begin
                  if (halt) begin
                     state     <= ST_IDLE;
                     seq       <= 1'b0;
                     seq_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     stop_q    <= 1'b0;
                  end else if (state == ST_SHIFT && bit_idx != '0) begin
                     bit_idx <= bit_idx - LEN_W'(1);
                     seq     <= sh_q[MAX_LEN-1];
                     sh_q    <= sh_q << 1;
                  end else if (state == ST_SHIFT && GAP_BITS > 0) begin
                     state     <= ST_GAP;
                     gap_cnt   <= '0;
                     seq       <= 1'b0;
                     seq_valid <= 1'b0;
                  end else if (state == ST_GAP && !gap_last) begin
                     gap_cnt <= gap_cnt + GW'(1);
                  end else begin
                     // New frame: end of a frame without gap, or end of gap.
                     state       <= ST_SHIFT;
                     sh_q        <= pat_q << 1;
                     seq         <= pat_q[MAX_LEN-1];
                     seq_valid   <= 1'b1;
                     bit_idx     <= len_q - LEN_W'(1);
                     frame_start <= 1'b1;
                     if (frame_cnt != '1) begin
                        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                     end
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx (MAX_LEN=16, BIT_CYCLES=4, GAP_BITS=2).
// Expected serial bits are queued at accept and popped by a monitor on each
// pattern bit_tick; transfer timing is checked against a vector table.
module tb_seq_pattern_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [15:0] pattern = '0;
   logic [4:0]  len = '0;
   logic [7:0]  repeat_cnt = '0;
   logic        stop = 1'b0;
   logic        seq, seq_valid, bit_tick, frame_start, busy, done;

   seq_pattern_tx #(
      .MAX_LEN    (16),
      .BIT_CYCLES (4),
      .GAP_BITS   (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .pattern     (pattern),
      .len         (len),
      .repeat_cnt  (repeat_cnt),
      .stop        (stop),
      .seq         (seq),
      .seq_valid   (seq_valid),
      .bit_tick    (bit_tick),
      .frame_start (frame_start),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard and per-transfer observations.
   logic exp_q[$];
   logic cur_exp = 1'b0;
   int   t_acc = 0;
   int   rel;
   int   tick_n, fs_n, busy_n, valid_n;
   int   fs_q[$];
   int   done_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         rel = cyc - t_acc + 1;
         if (bit_tick) tick_n++;
         if (frame_start) begin
            fs_n++;
            fs_q.push_back(rel);
         end
         if (done) done_q.push_back(rel);
         if (busy) busy_n++;
         if (seq_valid) begin
            valid_n++;
            if (bit_tick) begin
               if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
               else cur_exp = exp_q.pop_front();
            end
            check("seq_bit", {31'd0, seq}, {31'd0, cur_exp});
         end else begin
            check("seq_low", {31'd0, seq}, 32'd0);
         end
      end
   end

   function automatic logic [31:0] outs();
      return {25'd0, seq, seq_valid, bit_tick, frame_start, busy, done, start_ready};
   endfunction

   localparam logic [31:0] RESET_OUTS = 32'b0000001;

   task automatic push_frames(input logic [15:0] p, input int l, input int frames);
      int eff;
      eff = (l > 16) ? 16 : l;
      for (int f = 0; f < frames; f++)
         for (int b = eff - 1; b >= 0; b--)
            exp_q.push_back(p[b]);
   endtask

   task automatic do_accept(input logic [15:0] p, input logic [4:0] l, input logic [7:0] r);
      pattern = p; len = l; repeat_cnt = r; start_valid = 1'b1;
      @(posedge clk); #1;
      t_acc = cyc;
      start_valid = 1'b0;
      // Scramble the inputs: the transfer must use the latched copies.
      pattern = ~p; len = 5'd3; repeat_cnt = 8'd5;
      tick_n = 0; fs_n = 0; busy_n = 0; valid_n = 0;
      fs_q.delete(); done_q.delete();
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done) return;
      end
      check("done_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [15:0] pat;
      int          len;
      int          rep;
      int          stop_at;     // cycle after accept to pulse stop, 0 = none
      int          exp_done;    // cycle after accept where done pulses
      int          exp_frames;
      int          exp_gaps;
   } vec_t;

   vec_t vecs[9];

   task automatic run_vec(input int i);
      vec_t v;
      int   eff;
      v   = vecs[i];
      eff = (v.len > 16) ? 16 : v.len;
      exp_q.delete();
      push_frames(v.pat, v.len, v.exp_frames);
      do_accept(v.pat, 5'(v.len), 8'(v.rep));
      if (v.stop_at > 0) begin
         repeat (v.stop_at - 1) @(posedge clk);
         #1 stop = 1'b1;
         @(posedge clk); #1 stop = 1'b0;
      end
      wait_done(500);
      check($sformatf("v%0d_done_cycle", i), (done_q.size() > 0) ? done_q[0] : 32'hFFFF_FFFF, v.exp_done);
      check($sformatf("v%0d_done_outs", i), outs(), 32'b0000011);
      check($sformatf("v%0d_frames", i), fs_n, v.exp_frames);
      check($sformatf("v%0d_ticks", i), tick_n, v.exp_frames * eff + v.exp_gaps * 2);
      check($sformatf("v%0d_busy_cycles", i), busy_n, v.exp_done - 1);
      check($sformatf("v%0d_valid_cycles", i), valid_n, v.exp_frames * eff * 4);
      check($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
      if (v.exp_frames > 0)
         check($sformatf("v%0d_fs0", i), (fs_q.size() > 0) ? fs_q[0] : -1, 1);
      if (v.exp_frames > 1)
         check($sformatf("v%0d_fs1", i), (fs_q.size() > 1) ? fs_q[1] : -1, 1 + eff * 4 + 8);
   endtask

   initial begin
      //          pat      len rep stop done frames gaps
      vecs[0] = '{16'h01D3,  9, 1,   0,  37, 1, 0};  // single frame
      vecs[1] = '{16'h01D3,  9, 2,   0,  81, 2, 1};  // repeat with gap
      vecs[2] = '{16'h01D3,  9, 0,  50,  81, 2, 1};  // continuous, stop in frame 2
      vecs[3] = '{16'hA5C3,  0, 1,   0,   1, 0, 0};  // empty pattern
      vecs[4] = '{16'hBEEF, 20, 1,   0,  65, 1, 0};  // len clamped to 16
      vecs[5] = '{16'h0005,  3, 3,   0,  53, 3, 2};  // three short frames
      vecs[6] = '{16'h8001, 16, 1,   0,  65, 1, 0};  // full width
      vecs[7] = '{16'h0001,  1, 2,   0,  17, 2, 1};  // one-bit frames
      vecs[8] = '{16'h01D3,  9, 0,  40,  45, 1, 1};  // stop during gap

      // Power-on reset.
      repeat (2) @(posedge clk);
      #1 check("por_outs", outs(), RESET_OUTS);
      rst = 1'b0;
      #1 check("por_ready_after_rst", outs(), RESET_OUTS);

      for (int i = 0; i < 9; i++) run_vec(i);

      // Reset held for 3 cycles in the middle of a continuous transfer.
      exp_q.delete();
      push_frames(16'h01D3, 9, 3);
      do_accept(16'h01D3, 5'd9, 8'd0);
      repeat (20) @(posedge clk);
      #1 check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("rst_hold_outs_%0d", k), outs(), RESET_OUTS);
      end
      rst = 1'b0;
      exp_q.delete();
      #1 check("rst_release_outs", outs(), RESET_OUTS);
      @(posedge clk); #1 check("rst_idle_outs", outs(), RESET_OUTS);

      // start_valid held while busy, then reset at T+10 and a fresh start.
      exp_q.delete();
      push_frames(16'h01D3, 9, 1);
      pattern = 16'h01D3; len = 5'd9; repeat_cnt = 8'd1; start_valid = 1'b1;
      @(posedge clk); #1;
      t_acc = cyc;
      tick_n = 0; fs_n = 0; busy_n = 0; valid_n = 0;
      fs_q.delete(); done_q.delete();
      pattern = 16'hFFFF;
      check("busy_ready_low", {31'd0, start_ready}, 32'd0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      check("busy_no_reaccept", fs_n, 1);
      @(posedge clk); #1;
      check("rst_t11_outs", outs(), RESET_OUTS);
      rst = 1'b0;
      start_valid = 1'b0;
      run_vec(0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute guard against a hung run.
   initial begin
      #500000;
      $display("FAIL global_timeout: got cycle %0d, expected finish earlier", cyc);
      $fatal(1, "timeout");
   end

endmodule
